wb_copy_dma: RTL and testbench
==============================

// Module: wb_copy_dma
// PURPOSE
//  Wishbone primary (initiator) that copies LEN 32-bit words from SRC to DST, one read then one write per word.
//  Initiator-side counterpart to the CSR/peripheral secondaries on the 0xF000_0000 CSR bus.
//  Sits beside the core on the shared bus; used for SD-card/video buffer moves without core intervention.
// PARAMETERS
//  ADDR_SIZE       32   bus address width (byte addresses)
//  DATA_SIZE       32   bus data width; word stride = DATA_SIZE/8 bytes
//  LEN_WIDTH       16   width of length and progress counters
//  TIMEOUT_CYCLES  255  cycles without ack before abort (only with WB_COPY_DMA_TIMEOUT_EN)
// PORTS
//  clock        input   1          system clock, all state on rising edge
//  reset        input   1          asynchronous, active-low reset
//  wb_if_p      modport primary    wishbone_if: cyc, stb, we, addr, sel, dat_o_p out; dat_i_p, ack in
//  start        input   1          one-cycle request; sampled only in IDLE
//  src_addr     input   ADDR_SIZE  first source byte address, latched on accepted start
//  dst_addr     input   ADDR_SIZE  first destination byte address, latched on accepted start
//  len          input   LEN_WIDTH  number of words, latched on accepted start
//  busy         output  1          high from accepted start until DONE
//  done         output  1          one-cycle pulse at end of every accepted request
//  error        output  1          set on timeout abort; cleared by next accepted start
//  words_done   output  LEN_WIDTH  words fully written in the current/last request
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; cyc=stb=we=0, addr=0, sel=0, dat_o_p=0; busy=done=error=0; words_done=0.
//  States: IDLE, RD, WR, DONE (+ABORT with macro). Registered state; bus outputs decoded from state and registers.
//  IDLE: start && len!=0 -> latch src/dst/len, words_done=0, error=0 -> RD. start && len==0 -> DONE (no bus cycle).
//  RD: cyc=stb=1, we=0, sel=all ones, addr={src_q[ADDR_SIZE-1:2],2'b00}. On ack: data_q<=dat_i_p -> WR.
//  WR: cyc=stb=1, we=1, addr={dst_q[..:2],2'b00}, dat_o_p=data_q. On ack: src_q+=4, dst_q+=4, words_done+=1;
//      remaining==1 -> DONE else RD. cyc/stb stay high across RD->WR->RD; each ack closes exactly one transfer.
//  DONE: done=1 for one cycle, busy=0 on next cycle -> IDLE.
//  busy=1 in RD/WR/ABORT; 0 in IDLE and DONE.
//  start while busy: ignored, no effect on latched values.
//  Address increment wraps modulo 2^ADDR_SIZE (0xFFFF_FFFC -> 0x0000_0000); src/dst bits [1:0] ignored.
//  Latency per word: 1 cycle + secondary ack delay, per phase; zero-wait secondary -> 2 cycles/word.
//  ack outside RD/WR is ignored. Reset mid-transfer drops cyc/stb immediately; no partial-word bookkeeping.
// CONFIGURATION
//  `WB_COPY_DMA_TIMEOUT_EN defined: counter clears on each RD/WR entry and ack, increments each RD/WR cycle
//    without ack; reaching TIMEOUT_CYCLES -> ABORT (cyc=stb=0 one cycle), error=1 -> DONE.
//    words_done holds the count completed before abort.
//  Not defined: no counter; RD/WR wait indefinitely for ack; error tied 0; no ABORT state.
// STRUCTURE
//  wb_copy_dma_pkg: state enum typedef (IDLE/RD/WR/DONE/ABORT), WordStride byte constant, default timeout.
//  Sub-module wb_copy_dma_watchdog (counter + expiry flag); instantiated only under the macro.
//  Datapath (src_q, dst_q, remaining, data_q, words_done) and FSM stay in wb_copy_dma.
// TESTING
//  1 len=3 src=0x1000 dst=0x2000, ack 1 cycle after stb -> addrs R1000 W2000 R1004 W2004 R1008 W2008; data copied; words_done=3; one done.
//  2 start len=0 -> done pulse next cycle, cyc never asserted, busy stays 0, words_done=0.
//  3 second start during RD of len=2 job -> ignored; exactly 4 transfers with first job's addresses.
//  4 src=0xFFFFFFFC dst=0x3000 len=2 -> reads at 0xFFFFFFFC then 0x00000000; writes at 0x3000, 0x3004.
//  5 reset driven low mid-WR (asynchronously) -> cyc/stb/busy 0 same instant; after release, state IDLE and next start works.
//  6 macro on, TIMEOUT_CYCLES=8, secondary never acks -> cyc drops after 8 RD cycles, error=1, done pulse; macro off -> still in RD after 100 cycles.

Source files
------------

// File: rtl/wb_copy_dma_pkg.sv
// wb_copy_dma_pkg: shared types and constants for the Wishbone copy DMA.
//   dma_state_e    : FSM state encoding (ST_ABORT is only reachable when
//                    WB_COPY_DMA_TIMEOUT_EN is defined)
//   WordStride     : byte stride between consecutive 32-bit words
//   DefaultTimeout : default ack timeout in cycles for the watchdog
package wb_copy_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ABORT
  } dma_state_e;

  localparam int unsigned WordStride     = 4;
  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: classic Wishbone bus bundle.
//   primary   : drives cyc/stb/we/addr/sel/dat_o_p, receives dat_i_p/ack
//   secondary : mirror view for targets
interface wishbone_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32
);
  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [ADDR_SIZE-1:0]   addr;
  logic [DATA_SIZE/8-1:0] sel;
  logic [DATA_SIZE-1:0]   dat_o_p;
  logic [DATA_SIZE-1:0]   dat_i_p;
  logic                   ack;

  modport primary   (output cyc, stb, we, addr, sel, dat_o_p, input  dat_i_p, ack);
  modport secondary (input  cyc, stb, we, addr, sel, dat_o_p, output dat_i_p, ack);
endinterface

// File: rtl/wb_copy_dma_watchdog.sv
// wb_copy_dma_watchdog: ack timeout counter for the copy DMA.
//   clock, reset : system clock, async active-low reset
//   active       : high while a bus phase (RD/WR) is open
//   ack          : bus ack; restarts the count
//   expired      : high in the cycle that completes TIMEOUT_CYCLES cycles
//                  of an open phase without ack
module wb_copy_dma_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // cnt_q counts completed ack-less cycles of the current phase, so the
  // phase's N-th cycle sees N-1 and expiry fires on the last allowed cycle.
  assign expired = active && !ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               cnt_q <= '0;
    else if (!active || ack)  cnt_q <= '0;
    else if (!expired)        cnt_q <= cnt_q + CW'(1);
  end
endmodule

// File: rtl/wb_copy_dma.sv
// wb_copy_dma: Wishbone primary that copies len 32-bit words from src_addr to
// dst_addr, one read then one write per word.
//   clock, reset   : system clock, async active-low reset
//   wb_if_p        : Wishbone primary port
//   start          : one-cycle request, sampled only in IDLE
//   src_addr/dst_addr/len : job description, latched on accepted start
//   busy           : high while moving data (RD/WR/ABORT)
//   done           : one-cycle pulse at the end of every accepted request
//   error          : set by a timeout abort, cleared by the next accepted start
//   words_done     : words fully written in the current/last request
// Optional: define WB_COPY_DMA_TIMEOUT_EN to add an ack watchdog
// (TIMEOUT_CYCLES) that aborts a stuck transfer; otherwise RD/WR wait for
// ack indefinitely and error is tied low.
module wb_copy_dma
  import wb_copy_dma_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned LEN_WIDTH = 16
`ifdef WB_COPY_DMA_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  wishbone_if.primary          wb_if_p,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] src_addr,
  input  logic [ADDR_SIZE-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done
);
  dma_state_e           state_q, state_d;
  logic [ADDR_SIZE-1:0] src_q, dst_q;
  logic [LEN_WIDTH-1:0] remaining_q, words_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 ack, in_bus, accept, wd_expired;

  assign ack    = wb_if_p.ack;
  assign in_bus = (state_q == ST_RD) || (state_q == ST_WR);
  assign accept = (state_q == ST_IDLE) && start;

`ifdef WB_COPY_DMA_TIMEOUT_EN
  logic error_q;

  wb_copy_dma_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clock   (clock),
    .reset   (reset),
    .active  (in_bus),
    .ack     (ack),
    .expired (wd_expired)
  );

  assign error = error_q;
`else
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (len != '0) ? ST_RD : ST_DONE;
      // ack beats a same-cycle expiry: the transfer did complete.
      ST_RD:    if (ack) state_d = ST_WR;
                else if (wd_expired) state_d = ST_ABORT;
      ST_WR:    if (ack) state_d = (remaining_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD;
                else if (wd_expired) state_d = ST_ABORT;
      ST_DONE:  state_d = ST_IDLE;
`ifdef WB_COPY_DMA_TIMEOUT_EN
      ST_ABORT: state_d = ST_DONE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      data_q      <= '0;
`ifdef WB_COPY_DMA_TIMEOUT_EN
      error_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        words_q <= '0;
`ifdef WB_COPY_DMA_TIMEOUT_EN
        error_q <= 1'b0;
`endif
        // a zero-length job leaves the previous addresses untouched
        if (len != '0) begin
          src_q       <= src_addr;
          dst_q       <= dst_addr;
          remaining_q <= len;
        end
      end
      if (state_q == ST_RD && ack) data_q <= wb_if_p.dat_i_p;
      if (state_q == ST_WR && ack) begin
        // byte-address increment wraps naturally at 2^ADDR_SIZE
        src_q       <= src_q + ADDR_SIZE'(WordStride);
        dst_q       <= dst_q + ADDR_SIZE'(WordStride);
        remaining_q <= remaining_q - LEN_WIDTH'(1);
        words_q     <= words_q + LEN_WIDTH'(1);
      end
`ifdef WB_COPY_DMA_TIMEOUT_EN
      if (state_q == ST_ABORT) error_q <= 1'b1;
`endif
    end
  end

  // Bus outputs decode straight from state so a reset drops cyc/stb at once.
  assign wb_if_p.cyc     = in_bus;
  assign wb_if_p.stb     = in_bus;
  assign wb_if_p.we      = (state_q == ST_WR);
  assign wb_if_p.addr    = (state_q == ST_RD) ? {src_q[ADDR_SIZE-1:2], 2'b00} :
                           (state_q == ST_WR) ? {dst_q[ADDR_SIZE-1:2], 2'b00} : '0;
  assign wb_if_p.sel     = in_bus ? '1 : '0;
  assign wb_if_p.dat_o_p = (state_q == ST_WR) ? data_q : '0;

  assign busy       = in_bus || (state_q == ST_ABORT);
  assign done       = (state_q == ST_DONE);
  assign words_done = words_q;
endmodule

// File: tb/tb_wb_copy_dma.sv
module tb_wb_copy_dma;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, error;
  logic [LW-1:0] words_done;

  wishbone_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) wb ();

  always #5 clock = ~clock;

  wb_copy_dma #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_WIDTH(LW)
`ifdef WB_COPY_DMA_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_if_p    (wb),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- secondary model ----------------
  int          resp_wait   = 0;   // extra wait cycles before ack per phase
  int          stall_after = -1;  // stop acking after this many acks (-1: never)
  int          n_ack       = 0;
  logic [31:0] salt        = 32'h0;
  xfer_t       log_q[$];

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt ^ 32'h1234_5678;
  endfunction

  initial begin
    int   cnt;
    logic pa;
    cnt = 0;
    wb.ack = 1'b0;
    wb.dat_i_p = '0;
    forever begin
      @(posedge clock or negedge reset);
      #1;
      if (!reset) begin
        wb.ack = 1'b0;
        cnt = 0;
      end else begin
        pa = wb.ack;
        wb.ack = 1'b0;
        if (wb.cyc && wb.stb && !(stall_after >= 0 && n_ack >= stall_after)) begin
          if (pa) cnt = 0;
          if (cnt >= resp_wait) begin
            wb.ack = 1'b1;
            cnt = 0;
            n_ack++;
            if (wb.we) log_q.push_back('{1'b1, wb.addr, wb.dat_o_p});
            else begin
              wb.dat_i_p = rd_val(wb.addr);
              log_q.push_back('{1'b0, wb.addr, wb.dat_i_p});
            end
          end else cnt++;
        end else cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int n_done = 0, n_cyc = 0, n_busy = 0;
  initial forever begin
    @(negedge clock);
    if (done)   n_done++;
    if (wb.cyc) n_cyc++;
    if (busy)   n_busy++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Runs one job and checks it against the reference: word k reads
  // (src&~3)+4k and writes the same value to (dst&~3)+4k, addresses modulo
  // 2^32; every phase lasts w+1 cycles; done arrives right after the last write.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         input int w, input bit poke);
    xfer_t       exp_q[$];
    logic [31:0] ra, wa;
    int          c0, b0, d0, i, nexp, lim;
    log_q.delete();
    n_ack = 0;
    resp_wait = w;
    salt = $urandom;
    for (int k = 0; k < int'(l); k++) begin
      ra = (s & ~32'h3) + 32'(4 * k);
      wa = (d & ~32'h3) + 32'(4 * k);
      exp_q.push_back('{1'b0, ra, rd_val(ra)});
      exp_q.push_back('{1'b1, wa, rd_val(ra)});
    end
    nexp = 2 * int'(l) * (w + 1);
    c0 = n_cyc; b0 = n_busy; d0 = n_done;
    kick(s, d, l);
    i = 0;
    while (!done && i < nexp + 20) begin
      if (poke && i == 0) begin
        src_addr = ~s; dst_addr = ~d; len = 16'd7; start = 1'b1;
      end else start = 1'b0;
      @(negedge clock);
      i++;
    end
    start = 1'b0;
    chk("job_done_seen", done, 1);
    chk("job_latency", i, nexp);
    chk("job_busy_at_done", busy, 0);
    chk("job_words_done", words_done, l);
    chk("job_error", error, 0);
    @(negedge clock);
    #1;
    chk("job_done_one_cycle", done, 0);
    chk("job_idle_busy", busy, 0);
    chk("job_done_pulses", n_done - d0, 1);
    chk("job_cyc_cycles", n_cyc - c0, nexp);
    chk("job_busy_cycles", n_busy - b0, nexp);
    chk("job_xfer_count", log_q.size(), exp_q.size());
    lim = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int k = 0; k < lim; k++) begin
      chk($sformatf("xfer%0d_we", k),   log_q[k].we,   exp_q[k].we);
      chk($sformatf("xfer%0d_addr", k), log_q[k].addr, exp_q[k].addr);
      chk($sformatf("xfer%0d_data", k), log_q[k].data, exp_q[k].data);
    end
  endtask

  initial begin
    int c0, i;
    // reset state
    repeat (2) @(negedge clock);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_we", wb.we, 0);
    chk("rst_addr", wb.addr, 0);
    chk("rst_sel", wb.sel, 0);
    chk("rst_dat_o", wb.dat_o_p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_done", words_done, 0);
    reset = 1'b1;
    @(negedge clock);

    // basic copy, ack one cycle after stb
    run_job(32'h1000, 32'h2000, 16'd3, 1, 1'b0);
    // zero-length request
    run_job(32'h1100, 32'h2100, 16'd0, 0, 1'b0);
    // start while busy is ignored
    run_job(32'h1200, 32'h2200, 16'd2, 1, 1'b1);
    // address wrap, zero-wait secondary
    run_job(32'hFFFF_FFFC, 32'h3000, 16'd2, 0, 1'b0);
    // unaligned inputs: low address bits ignored
    run_job(32'h0000_8003, 32'h0000_9001, 16'd2, 2, 1'b0);

    // asynchronous reset in the middle of a write phase
    resp_wait = 1;
    kick(32'h4000, 32'h5000, 16'd3);
    for (int k = 0; k < 50 && !wb.we; k++) @(negedge clock);
    chk("mid_reach_wr", wb.we, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cyc", wb.cyc, 0);
    chk("mid_rst_stb", wb.stb, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_cyc", wb.cyc, 0);
    chk("post_rst_words", words_done, 0);
    run_job(32'h4100, 32'h5100, 16'd2, 0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 8; j++)
      run_job($urandom, $urandom, 16'($urandom_range(1, 5)), $urandom_range(0, 2), 1'b0);

    // secondary that stops acknowledging
`ifdef WB_COPY_DMA_TIMEOUT_EN
    stall_after = 0; n_ack = 0; resp_wait = 0;
    c0 = n_cyc;
    kick(32'h6000, 32'h7000, 16'd4);
    i = 0;
    while (!done && i < 40) begin @(negedge clock); i++; end
    #1;
    chk("to_done", done, 1);
    chk("to_cyc_cycles", n_cyc - c0, 8);
    chk("to_error", error, 1);
    chk("to_words", words_done, 0);
    @(negedge clock);
    stall_after = 2; n_ack = 0; resp_wait = 1;
    c0 = n_cyc;
    kick(32'h6100, 32'h7100, 16'd4);
    i = 0;
    while (!done && i < 60) begin @(negedge clock); i++; end
    #1;
    chk("to2_done", done, 1);
    chk("to2_cyc_cycles", n_cyc - c0, 12);
    chk("to2_error", error, 1);
    chk("to2_words", words_done, 1);
    @(negedge clock);
    stall_after = -1;
    run_job(32'h6200, 32'h7200, 16'd1, 0, 1'b0);
`else
    stall_after = 0; n_ack = 0; resp_wait = 0;
    kick(32'h6000, 32'h7000, 16'd2);
    repeat (100) @(negedge clock);
    chk("stall_cyc", wb.cyc, 1);
    chk("stall_we", wb.we, 0);
    chk("stall_busy", busy, 1);
    chk("stall_error", error, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    stall_after = -1;
    @(negedge clock);
    run_job(32'h6200, 32'h7200, 16'd1, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
